// File: rtl/cpu_pkg.sv
// cpu_pkg: register-file sizing shared by rename, ROB and the issue queues.
package cpu_pkg;
    localparam int PREG_NUM = 64;
    localparam int AREG_NUM = 32;
    localparam int PREG_W = $clog2(PREG_NUM);
    typedef logic [PREG_W-1:0] preg_idx_t;
endpackage

// File: rtl/free_compact.sv
// free_compact: packs the valid slots of an index vector to the front, in slot order.
module free_compact #(
    parameter int N = 4,
    parameter int W = 6,
    localparam int CW = $clog2(N+1)
) (
    input  logic [N-1:0]  valid,
    input  logic [W-1:0]  idx [N],
    output logic [W-1:0]  cmp_idx [N],
    output logic [CW-1:0] count
);
    int k;
    always_comb begin
        k = 0;
        for (int i = 0; i < N; i++) cmp_idx[i] = '0;
        for (int i = 0; i < N; i++)
            if (valid[i]) begin
                cmp_idx[k] = idx[i];
                k = k + 1;
            end
        count = CW'(k);
    end
endmodule

// File: rtl/preg_freelist.sv
// preg_freelist: circular free list of physical registers with a committed head for one-cycle flush recovery.
module preg_freelist #(
    parameter int PREG_NUM = cpu_pkg::PREG_NUM,
    parameter int AREG_NUM = cpu_pkg::AREG_NUM,
    parameter int ALLOC_W = 4,
    parameter int FREE_W = 4,
    localparam int DEPTH = PREG_NUM - AREG_NUM,
    localparam int PREG_W = $clog2(PREG_NUM),
    localparam int PTR_W = $clog2(DEPTH) + 1,
    localparam int NUM_W = $clog2(ALLOC_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [NUM_W-1:0]  alloc_num,
    output logic              alloc_ready,
    output logic [PREG_W-1:0] alloc_preg [ALLOC_W],
    input  logic              commit_valid,
    input  logic [NUM_W-1:0]  commit_num,
    input  logic [FREE_W-1:0] free_valid_vec,
    input  logic [PREG_W-1:0] free_preg [FREE_W],
    input  logic              recover,
    output logic [PTR_W-1:0]  free_count,
    output logic              empty
);
    localparam int IDX_W = PTR_W - 1;
    localparam int FCNT_W = $clog2(FREE_W + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("preg_freelist: PREG_NUM-AREG_NUM must be a power of two");
    end

    logic [PREG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  spec_head, cmt_head, tail, cmt_next, cmt_lag;
    logic [PREG_W-1:0] cmp_idx [FREE_W];
    logic [FCNT_W-1:0] free_num;
    logic              fire;

    free_compact #(.N(FREE_W), .W(PREG_W)) u_compact (
        .valid   (free_valid_vec),
        .idx     (free_preg),
        .cmp_idx (cmp_idx),
        .count   (free_num)
    );

    // Wrap bit in the pointers makes tail-head distinguish full from empty.
    assign free_count  = tail - spec_head;
    assign empty       = free_count == '0;
    assign alloc_ready = free_count >= PTR_W'(alloc_num);
    assign fire        = alloc_valid & alloc_ready & ~recover;
    assign cmt_next    = commit_valid ? cmt_head + PTR_W'(commit_num) : cmt_head;
    assign cmt_lag     = spec_head - cmt_next;

    for (genvar i = 0; i < ALLOC_W; i++) begin : g_rd
        assign alloc_preg[i] = mem[IDX_W'(spec_head + PTR_W'(i))];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= PREG_W'(AREG_NUM + i);
            spec_head <= '0;
            cmt_head  <= '0;
            tail      <= PTR_W'(DEPTH);
        end else begin
            for (int k = 0; k < FREE_W; k++)
                if (k < int'(free_num)) mem[IDX_W'(tail + PTR_W'(k))] <= cmp_idx[k];
            tail      <= tail + PTR_W'(free_num);
            cmt_head  <= cmt_next;
            spec_head <= recover ? cmt_next : fire ? spec_head + PTR_W'(alloc_num) : spec_head;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (int'(free_count) + int'(free_num) <= DEPTH);
            assert (cmt_lag <= PTR_W'(DEPTH));
        end
    end
endmodule

// File: tb/tb_preg_freelist.sv
// tb_preg_freelist: directed and model-checked random tests for the physical register free list.
module tb_preg_freelist;
    import cpu_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            alloc_valid = 1'b0;
    logic [2:0]      alloc_num = '0;
    logic            alloc_ready;
    preg_idx_t       alloc_preg [4];
    logic            commit_valid = 1'b0;
    logic [2:0]      commit_num = '0;
    logic [3:0]      free_valid_vec = '0;
    preg_idx_t       free_preg [4];
    logic            recover = 1'b0;
    logic [5:0]      free_count;
    logic            empty;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    preg_freelist dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_num      (alloc_num),
        .alloc_ready    (alloc_ready),
        .alloc_preg     (alloc_preg),
        .commit_valid   (commit_valid),
        .commit_num     (commit_num),
        .free_valid_vec (free_valid_vec),
        .free_preg      (free_preg),
        .recover        (recover),
        .free_count     (free_count),
        .empty          (empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_num = 0; commit_valid = 0; commit_num = 0;
        free_valid_vec = '0; recover = 0;
        for (int i = 0; i < 4; i++) free_preg[i] = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        alloc_valid = 1; alloc_num = 3; recover = 1; commit_valid = 1; commit_num = 2;
        free_valid_vec = 4'b1111;
        tick();
        tick();
        rst = 0;
        idle();
        #1;
        total++; if (free_count !== 6'd32) begin bad++; $display("FAIL reset_count got=%0d exp=32", free_count); end
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", alloc_ready); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL reset_empty got=%b exp=0", empty); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (alloc_preg[i] !== preg_idx_t'(32 + i)) begin bad++; $display("FAIL reset_preg%0d got=%0d exp=%0d", i, alloc_preg[i], 32 + i); end
        end
    endtask

    task automatic test_alloc_basic();
        do_reset();
        alloc_valid = 1; alloc_num = 4;
        #1;
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", alloc_ready); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (alloc_preg[i] !== preg_idx_t'(32 + i)) begin bad++; $display("FAIL basic_preg%0d got=%0d exp=%0d", i, alloc_preg[i], 32 + i); end
        end
        tick();
        idle();
        #1;
        total++; if (free_count !== 6'd28) begin bad++; $display("FAIL basic_count got=%0d exp=28", free_count); end
        total++; if (alloc_preg[0] !== 6'd36) begin bad++; $display("FAIL basic_next got=%0d exp=36", alloc_preg[0]); end
    endtask

    task automatic test_drain_and_sparse_free();
        do_reset();
        alloc_valid = 1; alloc_num = 4;
        for (int c = 0; c < 8; c++) tick();
        alloc_num = 0;
        #1;
        total++; if (free_count !== 6'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", free_count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty); end
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL zero_num_ready got=%b exp=1", alloc_ready); end
        alloc_num = 1;
        #1;
        total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL drain_ready got=%b exp=0", alloc_ready); end
        tick();
        idle();
        #1;
        total++; if (free_count !== 6'd0) begin bad++; $display("FAIL blocked_count got=%0d exp=0", free_count); end
        total++; if (alloc_preg[0] !== 6'd32) begin bad++; $display("FAIL blocked_head got=%0d exp=32", alloc_preg[0]); end
        free_valid_vec = 4'b1010;
        free_preg[0] = 6'd50; free_preg[1] = 6'd7; free_preg[2] = 6'd51; free_preg[3] = 6'd12;
        tick();
        idle();
        #1;
        total++; if (free_count !== 6'd2) begin bad++; $display("FAIL sparse_count got=%0d exp=2", free_count); end
        total++; if (alloc_preg[0] !== 6'd7) begin bad++; $display("FAIL sparse_preg0 got=%0d exp=7", alloc_preg[0]); end
        total++; if (alloc_preg[1] !== 6'd12) begin bad++; $display("FAIL sparse_preg1 got=%0d exp=12", alloc_preg[1]); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL sparse_empty got=%b exp=0", empty); end
    endtask

    task automatic test_recover();
        do_reset();
        alloc_valid = 1; alloc_num = 3;
        #1;
        total++; if (alloc_preg[2] !== 6'd34) begin bad++; $display("FAIL rec_alloc2 got=%0d exp=34", alloc_preg[2]); end
        tick();
        idle();
        commit_valid = 1; commit_num = 1;
        tick();
        idle();
        recover = 1; alloc_valid = 1; alloc_num = 2;
        tick();
        idle();
        #1;
        total++; if (alloc_preg[0] !== 6'd33) begin bad++; $display("FAIL rec_head got=%0d exp=33", alloc_preg[0]); end
        total++; if (free_count !== 6'd31) begin bad++; $display("FAIL rec_count got=%0d exp=31", free_count); end
        // commit and recover in the same cycle must restore to the post-commit head
        do_reset();
        alloc_valid = 1; alloc_num = 3;
        tick();
        idle();
        commit_valid = 1; commit_num = 1; recover = 1;
        tick();
        idle();
        #1;
        total++; if (alloc_preg[0] !== 6'd33) begin bad++; $display("FAIL rec_same_head got=%0d exp=33", alloc_preg[0]); end
        total++; if (free_count !== 6'd31) begin bad++; $display("FAIL rec_same_count got=%0d exp=31", free_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        alloc_valid = 1; alloc_num = 4;
        for (int c = 0; c < 7; c++) tick();
        alloc_num = 2;
        tick();
        #1;
        total++; if (free_count !== 6'd2) begin bad++; $display("FAIL b2b_pre_count got=%0d exp=2", free_count); end
        alloc_num = 2;
        commit_valid = 1; commit_num = 2;
        free_valid_vec = 4'b0011; free_preg[0] = 6'd3; free_preg[1] = 6'd4;
        #1;
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", alloc_ready); end
        total++; if (alloc_preg[1] !== 6'd63) begin bad++; $display("FAIL b2b_pre_preg1 got=%0d exp=63", alloc_preg[1]); end
        tick();
        idle();
        #1;
        total++; if (free_count !== 6'd2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", free_count); end
        total++; if (alloc_preg[0] !== 6'd3) begin bad++; $display("FAIL b2b_preg0 got=%0d exp=3", alloc_preg[0]); end
        total++; if (alloc_preg[1] !== 6'd4) begin bad++; $display("FAIL b2b_preg1 got=%0d exp=4", alloc_preg[1]); end
    endtask

    task automatic test_random();
        int q[$];
        int pool[$];
        int so, fc, n, c, nf, nfmax, win, pos, pops;
        bit av, rec;
        logic [3:0] vec;
        do_reset();
        for (int i = 0; i < 32; i++) begin q.push_back(32 + i); pool.push_back(i); end
        so = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            fc = q.size() - so;
            av = $urandom_range(0, 3) != 0;
            n = $urandom_range(0, 4);
            rec = $urandom_range(0, 19) == 0;
            c = (so == 0) ? 0 : $urandom_range(0, (so < 4) ? so : 4);
            nfmax = pool.size() - 32;
            if (nfmax > 4) nfmax = 4;
            nf = $urandom_range(0, nfmax);
            vec = '0;
            pops = 0;
            while (pops < nf) begin
                pos = $urandom_range(0, 3);
                if (!vec[pos]) begin vec[pos] = 1'b1; pops++; end
            end
            alloc_valid = av; alloc_num = 3'(n);
            commit_valid = (c != 0) || ($urandom_range(0, 1) == 1); commit_num = 3'(c);
            recover = rec;
            free_valid_vec = vec;
            for (int s = 0; s < 4; s++) begin
                if (vec[s]) begin
                    pos = $urandom_range(0, pool.size() - 1);
                    free_preg[s] = preg_idx_t'(pool[pos]);
                    pool.delete(pos);
                end else free_preg[s] = preg_idx_t'($urandom_range(0, 63));
            end
            #1;
            total++; if (free_count !== 6'(fc)) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, free_count, fc); end
            total++; if (empty !== (fc == 0)) begin bad++; $display("FAIL rnd_empty cyc=%0d got=%b exp=%b", cyc, empty, fc == 0); end
            total++; if (alloc_ready !== (n <= fc)) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, alloc_ready, n <= fc); end
            win = (fc < 4) ? fc : 4;
            for (int i = 0; i < win; i++) begin
                total++;
                if (alloc_preg[i] !== preg_idx_t'(q[so + i])) begin bad++; $display("FAIL rnd_preg%0d cyc=%0d got=%0d exp=%0d", i, cyc, alloc_preg[i], q[so + i]); end
                for (int j = i + 1; j < win; j++) begin
                    total++;
                    if (alloc_preg[i] === alloc_preg[j]) begin bad++; $display("FAIL rnd_dup cyc=%0d slot%0d=%0d slot%0d=%0d", cyc, i, alloc_preg[i], j, alloc_preg[j]); end
                end
            end
            if (commit_valid) begin
                for (int k = 0; k < c; k++) pool.push_back(q.pop_front());
                so -= c;
            end
            if (rec) so = 0;
            else if (av && n <= fc) so += n;
            for (int s = 0; s < 4; s++) if (vec[s]) q.push_back(int'(free_preg[s]));
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_alloc_basic();
        test_drain_and_sparse_free();
        test_recover();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
